// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main memory controller port.
// Sequences one transaction at a time: issue pulse, bounded wait, respond.
module main_memory_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_write_data,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [NUM_REQ-1:0]               req_error,
    output logic [DATA_WIDTH-1:0]            resp_read_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             busy,
    output logic                             main_memory_read_request,
    output logic                             main_memory_write_request,
    output logic [ADDR_WIDTH-1:0]            main_memory_address,
    output logic [DATA_WIDTH-1:0]            main_memory_write_data,
    input  logic [DATA_WIDTH-1:0]            main_memory_read_data,
    input  logic                             main_memory_ready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         pick;
    logic [IW-1:0]         hi_pick;
    logic [IW-1:0]         lo_pick;
    logic                  hi_found;
    logic                  lo_found;
    logic                  found;
    logic                  wr_q;
    logic                  ok_q;
    logic [CW-1:0]         cnt;
    logic                  timeout;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_REQ-1:0]    own;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[g] = req_write_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lowest set bit at or above ptr wins; otherwise lowest set bit below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_pick  = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_pick  = IW'(i);
                end
            end
        end
        found = hi_found | lo_found;
        pick  = hi_found ? hi_pick : lo_pick;
    end

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (found) state_nx = S_ISSUE;
            S_ISSUE:   state_nx = S_WAIT;
            S_WAIT:    if (main_memory_ready || timeout) state_nx = S_RESPOND;
            S_RESPOND: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= '0;
            idx            <= '0;
            wr_q           <= 1'b0;
            ok_q           <= 1'b0;
            cnt            <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            resp_read_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        idx    <= pick;
                        wr_q   <= req_write[pick];
                        addr_q <= addr_arr[pick];
                        data_q <= data_arr[pick];
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt  <= cnt + 1'b1;
                    ok_q <= main_memory_ready;
                    if (main_memory_ready && !wr_q)
                        resp_read_data <= main_memory_read_data;
                end
                S_RESPOND: begin
                    if (idx == IW'(NUM_REQ - 1)) ptr <= '0;
                    else                         ptr <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign own  = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    assign busy = (state != S_IDLE);

    assign grant     = busy ? own : '0;
    assign req_done  = (state == S_RESPOND && ok_q)  ? own : '0;
    assign req_error = (state == S_RESPOND && !ok_q) ? own : '0;

    assign main_memory_read_request  = (state == S_ISSUE) && !wr_q;
    assign main_memory_write_request = (state == S_ISSUE) && wr_q;
    assign main_memory_address       = addr_q;
    assign main_memory_write_data    = data_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter with a behavioural memory model.
// Checks latency, round-robin order, timeout, ready/timeout tie and reset abort.
module tb_main_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_address = '0;
    logic [63:0] req_write_data = '0;
    logic [1:0]  req_done;
    logic [1:0]  req_error;
    logic [31:0] resp_read_data;
    logic [1:0]  grant;
    logic        busy;
    logic        mm_rd;
    logic        mm_wr;
    logic [31:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata = '0;
    logic        mm_ready = 1'b0;
    logic        stray_ready = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;
    int viol = 0;
    int mem_delay = 2;
    int mem_cd = 0;
    int c;
    bit loaded = 1'b0;
    logic [31:0] mem [256];

    main_memory_arbiter #(
        .NUM_REQ(2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_address(req_address),
        .req_write_data(req_write_data),
        .req_done(req_done),
        .req_error(req_error),
        .resp_read_data(resp_read_data),
        .grant(grant),
        .busy(busy),
        .main_memory_read_request(mm_rd),
        .main_memory_write_request(mm_wr),
        .main_memory_address(mm_addr),
        .main_memory_write_data(mm_wdata),
        .main_memory_read_data(mm_rdata),
        .main_memory_ready(mm_ready | stray_ready)
    );

    always #5 clk = ~clk;

    // Memory model: ready pulses mem_delay cycles after the request pulse;
    // mem_delay of 0 means the memory never answers.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < 256; k++) mem[k] = 32'h0;
            mem[16] = 32'hDEAD_BEEF;
            loaded = 1'b1;
        end
        mm_ready = 1'b0;
        if (reset) mem_cd = 0;
        if (mem_cd > 0) begin
            mem_cd--;
            if (mem_cd == 0) begin
                mm_ready = 1'b1;
                mm_rdata = mem[mm_addr[9:2]];
            end
        end
        if (mm_rd || mm_wr) begin
            if (mm_wr) mem[mm_addr[9:2]] = mm_wdata;
            mem_cd = mem_delay;
        end
    end

    always @(negedge clk) begin
        if (!$onehot0(grant) || !$onehot0(req_done) ||
            !$onehot0(req_error) || (mm_rd && mm_wr))
            viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (cycles < 200 && req_done == 2'b00 && req_error == 2'b00) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        req_address[31:0]  = 32'h0000_0040;
        req_address[63:32] = 32'h0000_0080;
        tick();
        tick();

        // Reset state
        n_asrt++; assert ({busy, grant, req_done, req_error, mm_rd, mm_wr} === 9'b0) else begin n_fail++; $error("FAIL rst_ctrl: observed %b expected 0", {busy, grant, req_done, req_error, mm_rd, mm_wr}); end
        n_asrt++; assert ({mm_addr, mm_wdata, resp_read_data} === 96'h0) else begin n_fail++; $error("FAIL rst_data: observed %h expected 0", {mm_addr, mm_wdata, resp_read_data}); end
        reset = 1'b0;
        tick();

        // Requester 0 read of 0x40
        req_valid = 2'b01;
        req_write = 2'b00;
        tick();
        n_asrt++; assert ({mm_rd, mm_wr, grant, busy} === 5'b10011) else begin n_fail++; $error("FAIL t1_issue: observed %b expected 10011", {mm_rd, mm_wr, grant, busy}); end
        n_asrt++; assert (mm_addr === 32'h40) else begin n_fail++; $error("FAIL t1_addr: observed %h expected 40", mm_addr); end
        tick();
        n_asrt++; assert ({mm_rd, mm_wr, grant, req_done} === 6'b000100) else begin n_fail++; $error("FAIL t1_wait: observed %b expected 000100", {mm_rd, mm_wr, grant, req_done}); end
        wait_resp(c);
        n_asrt++; assert (c === 2) else begin n_fail++; $error("FAIL t1_latency: observed %0d expected 2", c); end
        n_asrt++; assert ({req_done, req_error} === 4'b0100) else begin n_fail++; $error("FAIL t1_done: observed %b expected 0100", {req_done, req_error}); end
        n_asrt++; assert (resp_read_data === 32'hDEAD_BEEF) else begin n_fail++; $error("FAIL t1_data: observed %h expected deadbeef", resp_read_data); end
        req_valid = 2'b00;
        tick();
        n_asrt++; assert ({busy, grant, req_done} === 5'b0) else begin n_fail++; $error("FAIL t1_idle: observed %b expected 0", {busy, grant, req_done}); end

        // Requester 1 write then read of 0x80
        req_valid = 2'b10;
        req_write = 2'b10;
        req_write_data[63:32] = 32'h1234_5678;
        tick();
        n_asrt++; assert ({mm_rd, mm_wr, grant} === 4'b0110) else begin n_fail++; $error("FAIL t2_wissue: observed %b expected 0110", {mm_rd, mm_wr, grant}); end
        n_asrt++; assert ({mm_addr, mm_wdata} === 64'h0000_0080_1234_5678) else begin n_fail++; $error("FAIL t2_wbus: observed %h expected 0000008012345678", {mm_addr, mm_wdata}); end
        wait_resp(c);
        n_asrt++; assert ({req_done, req_error} === 4'b1000) else begin n_fail++; $error("FAIL t2_wdone: observed %b expected 1000", {req_done, req_error}); end
        n_asrt++; assert (resp_read_data === 32'hDEAD_BEEF) else begin n_fail++; $error("FAIL t2_wkeep: observed %h expected deadbeef", resp_read_data); end
        req_valid = 2'b00;
        req_write = 2'b00;
        tick();
        req_valid = 2'b10;
        tick();
        n_asrt++; assert ({mm_rd, mm_wr, grant} === 4'b1010) else begin n_fail++; $error("FAIL t2_rissue: observed %b expected 1010", {mm_rd, mm_wr, grant}); end
        wait_resp(c);
        n_asrt++; assert (req_done === 2'b10) else begin n_fail++; $error("FAIL t2_rdone: observed %b expected 10", req_done); end
        n_asrt++; assert (resp_read_data === 32'h1234_5678) else begin n_fail++; $error("FAIL t2_rdata: observed %h expected 12345678", resp_read_data); end
        req_valid = 2'b00;
        tick();

        // Both requesters held: grants alternate
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  exp_d;
            logic [31:0] exp_r;
            exp_d = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            wait_resp(c);
            n_asrt++; assert (req_done === exp_d) else begin n_fail++; $error("FAIL t3_done%0d: observed %b expected %b", k, req_done, exp_d); end
            n_asrt++; assert (resp_read_data === exp_r) else begin n_fail++; $error("FAIL t3_data%0d: observed %h expected %h", k, resp_read_data, exp_r); end
            n_asrt++; assert (c === 4) else begin n_fail++; $error("FAIL t3_spacing%0d: observed %0d expected 4", k, c); end
            tick();
        end
        req_valid = 2'b00;
        tick();
        tick();

        // Timeout on requester 0, requester 1 pending
        mem_delay = 0;
        req_valid = 2'b11;
        tick();
        n_asrt++; assert ({mm_rd, grant} === 3'b101) else begin n_fail++; $error("FAIL t4_issue: observed %b expected 101", {mm_rd, grant}); end
        wait_resp(c);
        n_asrt++; assert (c === 65) else begin n_fail++; $error("FAIL t4_wait: observed %0d expected 65", c); end
        n_asrt++; assert ({req_done, req_error} === 4'b0001) else begin n_fail++; $error("FAIL t4_error: observed %b expected 0001", {req_done, req_error}); end
        mem_delay = 2;
        req_valid = 2'b10;
        tick();
        tick();
        n_asrt++; assert ({mm_rd, grant} === 3'b110) else begin n_fail++; $error("FAIL t4_next: observed %b expected 110", {mm_rd, grant}); end
        wait_resp(c);
        n_asrt++; assert ({req_done, req_error} === 4'b1000) else begin n_fail++; $error("FAIL t4_done: observed %b expected 1000", {req_done, req_error}); end
        req_valid = 2'b00;
        tick();

        // Ready on the last allowed wait cycle
        mem_delay = 64;
        req_valid = 2'b01;
        tick();
        wait_resp(c);
        n_asrt++; assert (c === 65) else begin n_fail++; $error("FAIL t5_wait: observed %0d expected 65", c); end
        n_asrt++; assert ({req_done, req_error} === 4'b0100) else begin n_fail++; $error("FAIL t5_tie: observed %b expected 0100", {req_done, req_error}); end
        n_asrt++; assert (resp_read_data === 32'hDEAD_BEEF) else begin n_fail++; $error("FAIL t5_data: observed %h expected deadbeef", resp_read_data); end
        req_valid = 2'b00;
        tick();

        // Reset during WAIT with requester 1 in flight
        mem_delay = 0;
        req_valid = 2'b10;
        tick();
        n_asrt++; assert (grant === 2'b10) else begin n_fail++; $error("FAIL t6_issue: observed %b expected 10", grant); end
        tick();
        tick();
        reset = 1'b1;
        req_valid = 2'b00;
        tick();
        n_asrt++; assert ({busy, grant, req_done, req_error, mm_rd, mm_wr} === 9'b0) else begin n_fail++; $error("FAIL t6_rst_ctrl: observed %b expected 0", {busy, grant, req_done, req_error, mm_rd, mm_wr}); end
        n_asrt++; assert ({mm_addr, mm_wdata, resp_read_data} === 96'h0) else begin n_fail++; $error("FAIL t6_rst_data: observed %h expected 0", {mm_addr, mm_wdata, resp_read_data}); end
        reset = 1'b0;
        mem_delay = 2;
        tick();
        stray_ready = 1'b1;
        tick();
        stray_ready = 1'b0;
        n_asrt++; assert ({busy, req_done, req_error, resp_read_data} === 37'h0) else begin n_fail++; $error("FAIL t6_stray: observed %h expected 0", {busy, req_done, req_error, resp_read_data}); end
        tick();
        n_asrt++; assert ({busy, req_done, req_error} === 5'b0) else begin n_fail++; $error("FAIL t6_quiet: observed %b expected 0", {busy, req_done, req_error}); end
        req_valid = 2'b11;
        tick();
        n_asrt++; assert (grant === 2'b01) else begin n_fail++; $error("FAIL t6_ptr: observed %b expected 01", grant); end
        wait_resp(c);
        n_asrt++; assert (req_done === 2'b01) else begin n_fail++; $error("FAIL t6_done: observed %b expected 01", req_done); end
        req_valid = 2'b00;
        tick();
        tick();

        n_asrt++; assert (viol === 0) else begin n_fail++; $error("FAIL onehot_monitor: observed %0d expected 0", viol); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Shares the single main memory controller port between NUM_REQ requesters (e.g. L2 miss-fill path and dirty write-back path).
- Arbitrates round-robin and sequences each transaction: issue a one-cycle request pulse, hold address/data stable, wait for main_memory_ready, then return data and a done pulse to the granted requester.
- Bounds every wait with a timeout counter.
- Serves one transaction at a time; no queuing.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, main memory address width
- DATA_WIDTH, 32, main memory data width
- TIMEOUT_CYCLES, 64, WAIT cycles allowed before error (>=4)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held until req_done/req_error
- req_write  in  NUM_REQ  1=write, 0=read; stable while req_valid
- req_address  in  NUM_REQ*ADDR_WIDTH  flattened; slice i = requester i
- req_write_data  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_error  out  NUM_REQ  one-cycle timeout pulse, one-hot
- resp_read_data  out  DATA_WIDTH  read data, valid with req_done
- grant  out  NUM_REQ  one-hot owner, ISSUE through RESPOND
- busy  out  1  high in any state but IDLE
- main_memory_read_request  out  1  to memory controller
- main_memory_write_request  out  1  to memory controller
- main_memory_address  out  ADDR_WIDTH  to memory controller
- main_memory_write_data  out  DATA_WIDTH  to memory controller
- main_memory_read_data  in  DATA_WIDTH  from memory controller
- main_memory_ready  in  1  from memory controller, one-cycle pulse

Behaviour:
- Reset (synchronous): state=IDLE; rr pointer=0; timeout counter=0. All outputs 0: req_done, req_error, resp_read_data, grant, busy, both memory requests, main_memory_address, main_memory_write_data. Reset overrides any in-flight transaction: no done/error pulse, memory requests drop the next cycle, late main_memory_ready is ignored.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from the rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - Latch grant index, write flag, address and write data into internal registers; go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - main_memory_read_request = !write or main_memory_write_request = write; never both.
  - Address/data driven from latched registers.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - Both requests low; address/data held stable.
  - Counter increments each cycle.
  - On main_memory_ready=1: latch main_memory_read_data into resp_read_data (reads only; writes leave it unchanged); go to RESPOND with done.
  - Else, when counter reaches TIMEOUT_CYCLES-1: go to RESPOND with error.
  - If ready and timeout coincide, ready wins.
- RESPOND (exactly 1 cycle):
  - req_done[grant] or req_error[grant] = 1.
  - rr pointer = grant index + 1 (mod NUM_REQ), updated on done or error.
  - Go to IDLE.
  - resp_read_data holds until the next read completes.
- main_memory_ready outside WAIT is ignored.
- req_valid changes after latching do not affect the current transaction. A requester dropping req_valid mid-transaction still receives its done pulse.
- A requester that keeps req_valid high in the cycle after req_done is treated as a new request and re-arbitrated. Fairness holds because the rr pointer has advanced past it.
- Latency: with ready asserted 2 cycles after the request pulse, a request valid in cycle 0 gives the request pulse in cycle 1, ready in cycle 3, and req_done in cycle 4. Minimum request-to-request spacing is 5 cycles.
- grant is one-hot or zero, never multi-hot. busy = (state != IDLE).

Test Plan:
- Reset, then requester 0 read at address 0x0000_0040 with memory pre-loaded 0xDEAD_BEEF -> read_request pulse in cycle 1 with address 0x40; req_done[0] in cycle 4; resp_read_data=0xDEAD_BEEF; no write_request.
- Requester 1 writes 0x1234_5678 to 0x80, then requester 1 reads 0x80 -> write_request pulse with data 0x1234_5678, req_done[1]; the read returns 0x1234_5678.
- req_valid=2'b11 held continuously, both reads -> grants alternate 0,1,0,1 over 4 transactions; grant never multi-hot; every req_done is one-hot.
- Memory model never asserts ready -> req_error[0] pulses after exactly TIMEOUT_CYCLES (64) WAIT cycles; no req_done; next request is granted to requester 1 if pending.
- Reset asserted during WAIT, and memory raises ready 1 cycle after reset deasserts -> no done/error pulse; outputs all 0; stray ready ignored; arbiter returns to IDLE and the pointer restarts at 0.
- Ready and timeout in the same cycle (ready forced at counter = TIMEOUT_CYCLES-1) -> req_done pulses, req_error stays 0, and data is latched.
